// File: rtl/spi_slave_rx_mode2_if.sv
// rtl/spi_slave_rx_mode2_if.sv - SPI pin and receive-result bundle for the mode-2 slave receiver
interface spi_slave_rx_mode2_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  In_spi_cs_n;
  logic                  In_spi_sclk;
  logic                  In_spi_mosi;
  logic [DATA_WIDTH-1:0] Out_rx_data;
  logic                  Out_rx_valid;
  logic                  Out_rx_busy;
  logic                  Out_rx_err;

  modport slave (
    input  In_spi_cs_n, In_spi_sclk, In_spi_mosi,
    output Out_rx_data, Out_rx_valid, Out_rx_busy, Out_rx_err
  );

  modport master (
    output In_spi_cs_n, In_spi_sclk, In_spi_mosi,
    input  Out_rx_data, Out_rx_valid, Out_rx_busy, Out_rx_err
  );
endinterface

// File: rtl/spi_slave_rx_mode2.sv
// rtl/spi_slave_rx_mode2.sv - SPI mode-2 (CPOL=1, CPHA=0) slave receiver with input synchronisers
module spi_slave_rx_mode2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                  In_clk,
  input logic                  In_rst,
  spi_slave_rx_mode2_if.slave  bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam int LS = SYNC_STAGES - 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RECV = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [FW-1:0]          flush_q, flush_d;
  logic                   armed_q, armed_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic flush_done;
  logic cs_fall;
  logic cs_rise;
  logic sclk_fall;
  logic mosi_bit;

  // Synchroniser shifting, edge detection, and arming of the CS_n falling-edge detector.
  // The detector stays disarmed until CS_n has been seen high with real pin data in the
  // chain, so a CS_n held low through reset cannot start a frame halfway through.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.In_spi_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.In_spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.In_spi_mosi};
    cs_prev_d   = cs_sync_q[LS];
    sclk_prev_d = sclk_sync_q[LS];
    flush_done  = (flush_q == FW'(SYNC_STAGES));
    flush_d     = flush_done ? flush_q : flush_q + FW'(1);
    armed_d     = armed_q | (flush_done & cs_sync_q[LS]);
    cs_fall     = armed_q & cs_prev_q & ~cs_sync_q[LS];
    cs_rise     = ~cs_prev_q & cs_sync_q[LS];
    sclk_fall   = sclk_prev_q & ~sclk_sync_q[LS];
    mosi_bit    = mosi_sync_q[LS];
  end

  // Frame FSM: shift on SCLK falling edges, publish full words, flag partial words at CS_n rise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_RECV: begin
        if (sclk_fall) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], mosi_bit};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            data_d  = {shift_q[DATA_WIDTH-2:0], mosi_bit};
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // The count used here already includes a same-cycle final edge, so a word that
        // completes together with CS_n rising ends cleanly.
        if (cs_rise) begin
          state_d = ST_IDLE;
          err_d   = (cnt_d != '0);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register for synchronisers, FSM and registered outputs.
  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.Out_rx_data  = data_q;
  assign bus.Out_rx_valid = valid_q;
  assign bus.Out_rx_busy  = (state_q == ST_RECV);
  assign bus.Out_rx_err   = err_q;
endmodule
